pipe_cla_sub_32bit: RTL

Two-stage pipelined 32-bit carry-lookahead subtractor with borrow-in/borrow-out, signed/unsigned status flags, and a valid/ready handshake on both sides. It is the subtraction counterpart to the 32-bit pipelined CLA adder and is built from the same 4-bit CLA slices: 8 slices in total, 4 per stage, with the difference formed as A + ~B + ~bin. It sits in the datapath wherever A − B or a compare result is needed at one operation per clock.

---
 rtl/pipe_cla_sub_32bit.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/pipe_cla_sub_32bit.sv
`default_nettype none
// ============================================================================
// Module   : pipe_cla_sub_32bit
// Purpose  : Two-stage pipelined 32-bit CLA subtractor (A - B - bin) with
//            borrow/zero/neg/ovf flags and valid/ready flow control.
// Revision : 1.0
// ============================================================================

module pipe_cla_sub_32bit_cla4 (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       c_i,
  output logic [3:0] s_o,
  output logic       c_o
);
  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] c;

  assign g = a_i & b_i;
  assign p = a_i ^ b_i;

  assign c[0] = c_i;
  assign c[1] = g[0] | (p[0] & c_i);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_i);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c_i);
  assign c_o  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c_i);

  assign s_o = p ^ c;
endmodule

module pipe_cla_sub_32bit (
  input  logic        CLK,
  input  logic        RESETn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        bin,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] diff,
  output logic        bout,
  output logic        zero,
  output logic        neg,
  output logic        ovf
);
  logic        en1;
  logic        en2;

  logic [4:0]  c_lo;
  logic [15:0] nb_lo;
  logic [15:0] s1_dlo_d;

  logic        s1_valid_q;
  logic [15:0] s1_dlo_q;
  logic        s1_c16_q;
  logic [15:0] s1_ahi_q;
  logic [15:0] s1_bhi_q;

  logic [4:0]  c_hi;
  logic [15:0] nb_hi;
  logic [15:0] dhi_d;
  logic [31:0] diff_d;
  logic        ovf_d;

  logic        out_valid_q;
  logic [31:0] diff_q;
  logic        bout_q;
  logic        zero_q;
  logic        neg_q;
  logic        ovf_q;

  assign en2      = !out_valid_q || out_ready;
  assign en1      = !s1_valid_q || en2;
  assign in_ready = en1;

  // Subtraction as A + ~B + ~bin; carry-out of the top is the inverted borrow.
  assign nb_lo   = ~B[15:0];
  assign c_lo[0] = ~bin;

  for (genvar i = 0; i < 4; i++) begin : g_lo
    pipe_cla_sub_32bit_cla4 u_slice (
      .a_i (A[4*i +: 4]),
      .b_i (nb_lo[4*i +: 4]),
      .c_i (c_lo[i]),
      .s_o (s1_dlo_d[4*i +: 4]),
      .c_o (c_lo[i+1])
    );
  end

  assign nb_hi   = ~s1_bhi_q;
  assign c_hi[0] = s1_c16_q;

  for (genvar i = 0; i < 4; i++) begin : g_hi
    pipe_cla_sub_32bit_cla4 u_slice (
      .a_i (s1_ahi_q[4*i +: 4]),
      .b_i (nb_hi[4*i +: 4]),
      .c_i (c_hi[i]),
      .s_o (dhi_d[4*i +: 4]),
      .c_o (c_hi[i+1])
    );
  end

  assign diff_d = {dhi_d, s1_dlo_q};
  assign ovf_d  = (s1_ahi_q[15] != s1_bhi_q[15]) && (diff_d[31] != s1_ahi_q[15]);

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      s1_valid_q <= 1'b0;
      s1_dlo_q   <= '0;
      s1_c16_q   <= 1'b0;
      s1_ahi_q   <= '0;
      s1_bhi_q   <= '0;
    end else if (en1) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_dlo_q <= s1_dlo_d;
        s1_c16_q <= c_lo[4];
        s1_ahi_q <= A[31:16];
        s1_bhi_q <= B[31:16];
      end
    end
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      out_valid_q <= 1'b0;
      diff_q      <= '0;
      bout_q      <= 1'b0;
      zero_q      <= 1'b0;
      neg_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else if (en2) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        diff_q <= diff_d;
        bout_q <= ~c_hi[4];
        zero_q <= (diff_d == 32'd0);
        neg_q  <= diff_d[31];
        ovf_q  <= ovf_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign diff      = diff_q;
  assign bout      = bout_q;
  assign zero      = zero_q;
  assign neg       = neg_q;
  assign ovf       = ovf_q;
endmodule

`default_nettype wire
